// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MF*/MT*; optional ULA_MULDIV_DIVZERO_EN adds div_by_zero and early divide-by-zero finish
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ULA_MULDIV_DIVZERO_EN
  output logic             div_by_zero,
`endif
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MTHI = 6'b010001;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] MTLO = 6'b010011;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [2*WIDTH-1:0] acc, mul_next, div_next, step_next, prod;
  logic [WIDTH-1:0] opb, abs_a, abs_b, quo, rem;
  logic [WIDTH:0] msum, dsub;
  logic [CW-1:0] count;
  logic is_div, neg_q, neg_r, dz, skip;
  logic md, sgn, take, zero_b, fin;
  assign md = func[5:2] == 4'b0110;
  assign sgn = ~func[0];
  assign zero_b = b == '0;
  assign take = start & (state == IDLE) & ~skip;
  assign abs_a = (sgn & a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn & b[WIDTH-1]) ? -b : b;
  assign busy = state != IDLE;
  assign stall = start & (busy | (md & ~skip));
  assign result = func == MFHI ? hi : func == MFLO ? lo : '0;
  assign fin = (state == CALC) & (count == CW'(WIDTH - 1));
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {msum, acc[WIDTH-1:1]};
  assign dsub = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign div_next = dsub[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign step_next = is_div ? div_next : mul_next;
  assign prod = neg_q ? -step_next : step_next;
  assign quo = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
  assign rem = neg_r ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  // FSM: the final step's sign-corrected result is written on entry to FIX so HI/LO are valid while done is high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      opb <= '0;
      count <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      skip <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
`ifdef ULA_MULDIV_DIVZERO_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      skip <= 1'b0;
`ifdef ULA_MULDIV_DIVZERO_EN
      div_by_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (take & md) begin
            acc <= {{WIDTH{1'b0}}, abs_a};
            opb <= abs_b;
            count <= '0;
            is_div <= func[1];
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn & a[WIDTH-1];
            dz <= func[1] & zero_b;
            state <= CALC;
`ifdef ULA_MULDIV_DIVZERO_EN
            if (func[1] & zero_b) begin
              hi <= a;
              lo <= '1;
              done <= 1'b1;
              div_by_zero <= 1'b1;
              state <= FIX;
            end
`endif
          end else if (take & (func == MTHI)) begin
            hi <= a;
          end else if (take & (func == MTLO)) begin
            lo <= a;
          end
        end
        CALC: begin
          acc <= step_next;
          count <= count + 1'b1;
          if (fin) begin
            hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
            lo <= is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];
            done <= 1'b1;
            state <= FIX;
`ifdef ULA_MULDIV_DIVZERO_EN
            div_by_zero <= dz;
`endif
          end
        end
        FIX: begin
          state <= IDLE;
          skip <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_muldiv.sv
// tb_ula_muldiv: directed vectors for ula_muldiv (default build or ULA_MULDIV_DIVZERO_EN)
module tb_ula_muldiv;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [5:0] func = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result, hi, lo;
  logic busy, done, stall;
  int tests = 0;
  int fails = 0;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
`ifdef ULA_MULDIV_DIVZERO_EN
  logic div_by_zero;
  localparam int DZ_CYC = 1;
`else
  localparam int DZ_CYC = 33;
`endif
  ula_muldiv #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .func(func),
    .a(a),
    .b(b),
`ifdef ULA_MULDIV_DIVZERO_EN
    .div_by_zero(div_by_zero),
`endif
    .result(result),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done),
    .stall(stall)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic run(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input int ecyc);
    int k = 0;
    int idle = 0;
    start = 1'b1;
    func = f;
    a = x;
    b = y;
    #1;
    chk({tag, "_accept_stall"}, stall, 1);
    while (!done && k < 40) begin
      tick();
      k++;
      if (!busy) idle++;
    end
    chk({tag, "_done_cycle"}, k, ecyc);
    chk({tag, "_busy_gap"}, idle, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_done_stall"}, stall, 1);
`ifdef ULA_MULDIV_DIVZERO_EN
    chk({tag, "_dbz"}, div_by_zero, f[1] && y == 0);
`endif
    tick();
    start = 1'b0;
    #1;
    chk({tag, "_after_done"}, {busy, done}, 0);
    tick();
  endtask
  initial begin
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy_done_stall", {busy, done, stall}, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    run("mult_neg", MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("multu", MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 33);
    run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run("mult_mix", MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    run("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run("divu_zero", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, DZ_CYC);
    run("div_zero_neg", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, DZ_CYC);
    run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    start = 1'b1;
    func = MTHI;
    a = 32'h1234;
    #1;
    chk("mthi_stall", stall, 0);
    tick();
    func = MFHI;
    #1;
    chk("mfhi_stall", stall, 0);
    chk("mfhi_result", result, 32'h00001234);
    tick();
    func = MTLO;
    a = 32'h5555;
    tick();
    func = MFLO;
    #1;
    chk("mflo_result", result, 32'h00005555);
    func = 6'b100000;
    #1;
    chk("other_result", result, 0);
    func = MULT;
    a = 32'd3;
    b = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) begin
        func = MFLO;
        #1;
        chk("mid_stall", stall, 1);
        chk("mid_result", result, 32'h00005555);
        chk("mid_hi", hi, 32'h00001234);
      end
    end
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_hilo", {hi, lo}, 0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("post_abort", {busy, done, hi, lo}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
